// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for eight requesters sharing a 32-bit 8:1 select datapath.
// Grants one owner at a time, drives the mux select and registers the selected word.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD   = 16,
  parameter int unsigned HOLD_WIDTH = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  request,
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  input  logic [31:0] input3,
  input  logic [31:0] input4,
  input  logic [31:0] input5,
  input  logic [31:0] input6,
  input  logic [31:0] input7,
  input  logic [31:0] input8,
  output logic [7:0]  grant,
  output logic [2:0]  select,
  output logic        busy,
  output logic [31:0] result,
  output logic        result_valid
);

  typedef enum logic [0:0] {StIdle, StGrant} state_t;

  state_t                r_state;
  logic [2:0]            r_ptr;
  logic [HOLD_WIDTH-1:0] r_hold;
  logic [7:0]            r_grant;
  logic [2:0]            r_select;
  logic [31:0]           r_result;
  logic                  r_valid;

  logic [31:0] w_data [8];
  logic [31:0] w_sel_data;
  logic        w_release;
  logic        w_timeout;
  logic [2:0]  w_arb_ptr;
  logic        w_found;
  logic [2:0]  w_pick;

  always_comb begin
    w_data[0] = input1;
    w_data[1] = input2;
    w_data[2] = input3;
    w_data[3] = input4;
    w_data[4] = input5;
    w_data[5] = input6;
    w_data[6] = input7;
    w_data[7] = input8;
  end

  assign w_sel_data = w_data[r_select];

  // While granted, r_select is the owner index.
  assign w_release = (r_state == StGrant) && !request[r_select];
  assign w_timeout = (MAX_HOLD != 0) && (r_state == StGrant) && request[r_select] &&
                     (r_hold == HOLD_WIDTH'(MAX_HOLD));

  // Ending a tenure re-arbitrates starting just past the outgoing owner.
  assign w_arb_ptr = (r_state == StGrant) ? (r_select + 3'd1) : r_ptr;

  always_comb begin
    logic [2:0] idx;
    w_found = 1'b0;
    w_pick  = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = w_arb_ptr + 3'(k);
      if (!w_found && request[idx]) begin
        w_found = 1'b1;
        w_pick  = idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_ptr    <= 3'd0;
      r_hold   <= '0;
      r_grant  <= 8'd0;
      r_select <= 3'd0;
      r_result <= 32'd0;
      r_valid  <= 1'b0;
    end else begin
      if (r_grant != 8'd0) begin
        r_result <= w_sel_data;
        r_valid  <= 1'b1;
      end else begin
        r_valid  <= 1'b0;
      end

      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_grant  <= 8'd1 << w_pick;
            r_select <= w_pick;
            r_hold   <= HOLD_WIDTH'(1);
            r_state  <= StGrant;
          end
        end
        StGrant: begin
          if (w_release || w_timeout) begin
            r_ptr <= r_select + 3'd1;
            if (w_found) begin
              r_grant  <= 8'd1 << w_pick;
              r_select <= w_pick;
              r_hold   <= HOLD_WIDTH'(1);
            end else begin
              r_grant <= 8'd0;
              r_hold  <= '0;
              r_state <= StIdle;
            end
          end else if ((MAX_HOLD != 0) && (r_hold != '1)) begin
            r_hold <= r_hold + HOLD_WIDTH'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign grant        = r_grant;
  assign select       = r_select;
  assign busy         = |r_grant;
  assign result       = r_result;
  assign result_valid = r_valid;

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 32-bit 8:1 select datapath.
- Up to eight requesters compete for the shared result bus. The block grants one requester at a time and drives the 3-bit mux select.
- Registers the selected 32-bit word onto the result bus with a valid flag.
- A hold-timeout forces re-arbitration so no requester starves the others.

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles per tenure; 0 disables the timeout.
- HOLD_WIDTH, 5: width of the hold counter; must satisfy 2^HOLD_WIDTH > MAX_HOLD.

Ports:
- clock  input  1  single system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clock
- request  input  8  per-requester level request; bit k = requester k+1
- input1..input8  input  32 each  data word offered by requester 1..8
- grant  output  8  one-hot grant, registered; all-zero when idle
- select  output  3  mux select = index of granted requester (0..7), registered
- busy  output  1  1 while a grant is active
- result  output  32  registered data word of the granted requester
- result_valid  output  1  1 when result holds a word captured under a grant

Behaviour:
- Reset (reset=0 at a rising edge) forces:
  - grant=0, select=0, busy=0, result=0, result_valid=0.
  - Internal pointer=0, hold counter=0, state=IDLE.
  - Reset mid-tenure aborts the grant the same edge; no result is captured on that edge.
- State IDLE:
  - On each edge, if request!=0, pick the first set bit scanning upward from pointer, wrapping 7->0.
  - Register grant/select to that index and enter GRANT. Hold counter=1.
  - Latency from request to grant: exactly one edge.
- State GRANT, owner o:
  - Owner release: if request[o]=0 at an edge, the tenure ends that edge and pointer=(o+1) mod 8.
    - If other requests are present, re-arbitrate the same edge: new grant is visible the next cycle with no idle gap.
    - Otherwise go to IDLE with grant=0, busy=0.
  - Timeout: if MAX_HOLD!=0 and the hold counter equals MAX_HOLD at an edge with request[o]=1, force re-arbitration with pointer=(o+1) mod 8.
    - If o is the only requester, o is re-granted and the hold counter resets to 1.
  - Otherwise grant holds and the hold counter increments; it saturates, no wrap.
  - With MAX_HOLD=0 there is no timeout and the counter is inert.
- Simultaneous events:
  - Release and timeout on the same edge are treated as release.
  - New requests arriving during a tenure wait; they never preempt.
- Outputs:
  - grant is always one-hot or zero.
  - select equals the binary index of grant whenever busy=1, and holds its last value when idle.
  - busy = |grant.
- Data path:
  - At each edge where busy=1 (pre-edge value), result <= input[select] and result_valid <= 1.
  - Otherwise result holds its value and result_valid <= 0.
  - result therefore lags grant by one cycle; the word captured is the one present during the granted cycle.
- Fairness: after a requester is served, it has the lowest priority at the next arbitration.

Test Plan:
- Reset: hold reset=0 for 2 edges with request=8'hFF -> grant=0, select=0, busy=0, result=0, result_valid=0. Release reset -> grant=8'h01 one edge later.
- Round-robin rotation: MAX_HOLD=16, request=8'hFF constant, each owner drops its bit for one cycle after 2 grant cycles -> grant sequence 01,02,04,...,80,01. select tracks 0..7,0. No idle cycle between tenures.
- Timeout: MAX_HOLD=4, request=8'h05 held -> requester 1 granted exactly 4 cycles, then requester 3 for 4 cycles, then requester 1. With request=8'h04 only -> requester 3 re-granted, busy stays 1.
- Data capture: grant requester 6 with input6=32'hDEADBEEF, all other inputs 32'h0 -> result=32'hDEADBEEF and result_valid=1 one cycle after grant. After release and idle -> result_valid=0 and result stays 32'hDEADBEEF.
- Wrap and priority: pointer=7 (after serving requester 7), request=8'h81 -> grant=8'h80 (requester 8) first, then 8'h01.
- Reset mid-tenure: reset=0 during grant=8'h10 -> next cycle all outputs zero. After reset release with request=8'h30 -> grant=8'h10 (pointer reset to 0).
